// File: rtl/pipeline_controller.sv
// pipeline_controller: hazard/branch/memory-stall controller for a 5-stage pipeline; PIPE_PERF_CNT_EN enables the performance counters
module pipeline_controller #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       mem_dest,
    input  logic             exe_wb_en,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_freeze,
    output logic             id_freeze,
    output logic             exe_freeze,
    output logic             mem_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        hazard, mem_stall, err, freeze_all;
    assign hazard = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1)) |
                    (id_two_src & ((exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2))));
    assign err        = state_q == ERROR;
    assign freeze_all = mem_stall | err;
    assign exe_freeze = freeze_all;
    assign mem_freeze = freeze_all;
    assign if_freeze  = freeze_all | (~branch_taken & hazard);
    assign id_freeze  = if_freeze;
    assign if_flush   = ~freeze_all & branch_taken;
    assign id_flush   = ~freeze_all & (branch_taken | hazard);
    assign mem_error  = err;
    // memory-wait sequencing: stall detection, wait counting and timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_stall  = 1'b0;
        case (state_q)
            RUN: begin
                mem_stall = mem_req & ~mem_ready;
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            MEM_WAIT: begin
                mem_stall = ~mem_ready;
                if (mem_ready) state_d = RUN;
                else if (wait_cnt_q >= 16'(MEM_TIMEOUT)) state_d = ERROR;
                else wait_cnt_d = wait_cnt_q + 16'd1;
            end
            default: ;
        endcase
    end
    // state register; ERROR is left only through reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;
    // saturating counters of frozen-fetch and fetch-flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (if_freeze && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (if_flush && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed and random checks of pipeline_controller against a rule-level model
module tb_pipeline_controller;
    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic id_two_src, exe_wb_en, mem_wb_en, branch_taken, mem_req, mem_ready;
    logic if_freeze, id_freeze, exe_freeze, mem_freeze, if_flush, id_flush, mem_error;
    logic [CW-1:0] stall_cycles, flush_count;
    int checks = 0, errors = 0;
    bit m_wait, m_err;
    int m_waited, m_stall, m_flush;
    bit e_iff, e_idf, e_fa, e_ifl, e_idl;

    pipeline_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .if_freeze(if_freeze), .id_freeze(id_freeze), .exe_freeze(exe_freeze), .mem_freeze(mem_freeze),
        .if_flush(if_flush), .id_flush(id_flush), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_src1 = 4'd1; id_src2 = 4'd2; id_two_src = 1'b0;
        exe_dest = 4'd5; mem_dest = 4'd6; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // expected pipeline-control outputs from the priority rules: stall/error, then branch, then hazard
    task automatic expect_out(input string tag);
        bit haz, stl;
        haz = (exe_wb_en && exe_dest == id_src1) || (mem_wb_en && mem_dest == id_src1) ||
              (id_two_src && ((exe_wb_en && exe_dest == id_src2) || (mem_wb_en && mem_dest == id_src2)));
        stl = m_wait ? !mem_ready : (mem_req && !mem_ready);
        e_fa = m_err || stl;
        e_iff = e_fa || (!branch_taken && haz);
        e_idf = e_iff;
        e_ifl = !e_fa && branch_taken;
        e_idl = !e_fa && (branch_taken || haz);
        chk({tag, ".if_freeze"}, 32'(if_freeze), 32'(e_iff));
        chk({tag, ".id_freeze"}, 32'(id_freeze), 32'(e_idf));
        chk({tag, ".exe_freeze"}, 32'(exe_freeze), 32'(e_fa));
        chk({tag, ".mem_freeze"}, 32'(mem_freeze), 32'(e_fa));
        chk({tag, ".if_flush"}, 32'(if_flush), 32'(e_ifl));
        chk({tag, ".id_flush"}, 32'(id_flush), 32'(e_idl));
    endtask

    task automatic cycle(input string tag);
        #3;
        expect_out(tag);
        @(posedge clk);
        if (PERF && e_iff && m_stall < MAXC) m_stall++;
        if (PERF && e_ifl && m_flush < MAXC) m_flush++;
        if (!m_err) begin
            if (m_wait) begin
                if (mem_ready) m_wait = 0;
                else if (m_waited >= TO) begin m_err = 1; m_wait = 0; end
                else m_waited++;
            end else if (mem_req && !mem_ready) begin
                m_wait = 1; m_waited = 1;
            end
        end
        #1;
        chk({tag, ".mem_error"}, 32'(mem_error), 32'(m_err));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        chk({tag, ".flush_count"}, 32'(flush_count), 32'(m_flush));
    endtask

    // asynchronous reset applied mid-cycle; clearing must be visible before any clock edge
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        chk({tag, ".rst_mem_error"}, 32'(mem_error), 32'd0);
        chk({tag, ".rst_stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, ".rst_flush"}, 32'(flush_count), 32'd0);
        expect_out({tag, ".in_rst"});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        m_wait = 0; m_err = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        do_reset("init");
        cycle("idle");
        id_src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        cycle("req037");
        chk("req037.bubble", {28'd0, if_freeze, id_freeze, id_flush, if_flush}, 32'b1110);
        branch_taken = 1'b1;
        cycle("req038");
        idle(); id_two_src = 1'b1; id_src2 = 4'd6; mem_wb_en = 1'b1;
        cycle("src2_mem_haz");
        id_two_src = 1'b0;
        cycle("src2_unused");
        idle(); mem_wb_en = 1'b1; mem_dest = 4'd1; exe_wb_en = 1'b0; exe_dest = 4'd1;
        cycle("src1_mem_haz");
        idle(); do_reset("pre039");
        mem_req = 1'b1;
        repeat (3) cycle("req039_wait");
        mem_ready = 1'b1;
        cycle("req039_done");
        chk("req039.stall_total", 32'(stall_cycles), PERF ? 32'd3 : 32'd0);
        idle(); mem_req = 1'b1; mem_ready = 1'b1;
        cycle("ready_same_cycle");
        idle(); do_reset("pre040");
        mem_req = 1'b1;
        repeat (1 + TO) cycle("req040_wait");
        chk("req040.error", 32'(mem_error), 32'd1);
        branch_taken = 1'b1; id_src1 = 4'd5; exe_wb_en = 1'b1; mem_ready = 1'b1;
        repeat (3) cycle("req040_err_hold");
        do_reset("req040_clear");
        idle(); cycle("post040");
        do_reset("pre041");
        mem_req = 1'b1; branch_taken = 1'b1;
        repeat (3) cycle("req041_wait");
        mem_ready = 1'b1;
        cycle("req041_fire");
        idle();
        cycle("req041_after");
        chk("req041.flush_total", 32'(flush_count), PERF ? 32'd1 : 32'd0);
        mem_req = 1'b1;
        repeat (2) cycle("req042_wait");
        do_reset("req042");
        idle(); cycle("post042");
        id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
        repeat (MAXC + 4) cycle("sat_stall");
        chk("sat.stall_max", 32'(stall_cycles), PERF ? 32'(MAXC) : 32'd0);
        idle();
        for (int i = 0; i < 400; i++) begin
            id_src1 = 4'($urandom_range(0, 3)); id_src2 = 4'($urandom_range(0, 3));
            exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
            id_two_src = 1'($urandom); exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 60) == 0) do_reset("rand");
            else cycle("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the memory-wait cycle limit (1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, the performance-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports id_src1 and id_src2, input, 4 each: source registers of the instruction in ID.
REQ-006 SHALL have port id_two_src, input, 1: the instruction in ID reads id_src2.
REQ-007 SHALL have ports exe_dest and mem_dest, input, 4 each: destinations in EX and MEM.
REQ-008 SHALL have ports exe_wb_en and mem_wb_en, input, 1 each: write-back enables of EX and MEM.
REQ-009 SHALL have port branch_taken, input, 1: the EX-stage branch resolved taken.
REQ-010 SHALL have port mem_req, input, 1: the MEM stage holds a load or store.
REQ-011 SHALL have port mem_ready, input, 1: data memory completes the access this cycle.
REQ-012 SHALL have ports if_freeze, id_freeze, exe_freeze and mem_freeze, output, 1 each: hold the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 SHALL have ports if_flush and id_flush, output, 1 each: clear IF/ID and ID/EX to a bubble on the next edge.
REQ-014 SHALL have port mem_error, output, 1: sticky memory-timeout flag.
REQ-015 SHALL have ports stall_cycles and flush_count, output, CNT_W each: performance counters.

Function
REQ-016 SHALL implement a state machine with states RUN, MEM_WAIT and ERROR.
REQ-017 SHALL define hazard = (exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1) | (id_two_src & the same two matches against id_src2), combinationally.
REQ-018 SHALL define mem_stall = mem_req & ~mem_ready in RUN, and ~mem_ready in MEM_WAIT.
REQ-019 SHALL, when mem_stall is 1, drive all four freezes to 1 and both flushes to 0, with no other action.
REQ-020 SHALL, when mem_stall is 0 and branch_taken is 1, drive if_flush=1 and id_flush=1 with all freezes 0; branch takes priority over hazard.
REQ-021 SHALL, when mem_stall, branch_taken are 0 and hazard is 1, drive if_freeze=1, id_freeze=1, id_flush=1 (bubble) and if_flush=0.
REQ-022 SHALL otherwise drive all freezes and flushes to 0.
REQ-023 SHALL transition RUN->MEM_WAIT on mem_req & ~mem_ready, and reset wait_cnt to 1.
REQ-024 SHALL, on mem_req & mem_ready in the same RUN cycle, stay in RUN with zero stall cycles.
REQ-025 SHALL, in MEM_WAIT, increment wait_cnt each cycle, and transition MEM_WAIT->RUN in the cycle mem_ready=1.
REQ-026 SHALL transition MEM_WAIT->ERROR when wait_cnt reaches MEM_TIMEOUT without mem_ready; mem_ready in that same cycle wins (->RUN).
REQ-027 SHALL, in ERROR, drive all four freezes to 1 and mem_error=1 until reset; ERROR is exited only by rst.
REQ-028 SHALL hold the branch flush while frozen by a memory stall: branch_taken stays held in EX and the flush fires in the first unstalled cycle.
REQ-029 SHALL ignore hazard and branch_taken entirely while in ERROR.

Reset
REQ-030 SHALL, on rst=1 asynchronously, set state=RUN, wait_cnt=0, mem_error=0 and both counters to 0.
REQ-031 SHALL, on rst asserted mid-MEM_WAIT, abandon the access; the freezes derive from RUN in the next cycle.
REQ-032 SHALL, during reset, drive outputs per RUN with the current inputs; all flags are registered 0.

Configuration
REQ-033 SHALL, with PIPE_PERF_CNT_EN defined, increment stall_cycles in any cycle with if_freeze=1.
REQ-034 SHALL, with PIPE_PERF_CNT_EN defined, increment flush_count on each cycle with if_flush=1.
REQ-035 SHALL saturate both counters at all-ones and never wrap.
REQ-036 SHALL, without PIPE_PERF_CNT_EN, tie stall_cycles and flush_count to 0 and synthesise no counter flops.

Verification
REQ-037 SHALL cover: id_src1=3, exe_dest=3, exe_wb_en=1 -> if_freeze=1, id_freeze=1, id_flush=1, if_flush=0 for that cycle.
REQ-038 SHALL cover: hazard=1 and branch_taken=1 together -> if_flush=1, id_flush=1, all freezes 0.
REQ-039 SHALL cover: mem_req=1, mem_ready low for 3 cycles, then high -> 3 cycles of full freeze, RUN on the 4th, stall_cycles=3.
REQ-040 SHALL cover: mem_req=1 with mem_ready never high, MEM_TIMEOUT=4 -> ERROR after 4 wait cycles, mem_error=1, freezes held; rst clears all.
REQ-041 SHALL cover: branch_taken=1 during MEM_WAIT -> no flush until mem_ready, then if_flush=1 exactly one cycle, flush_count=1.
REQ-042 SHALL cover: rst pulsed mid-MEM_WAIT -> state RUN, counters 0, mem_error 0 immediately (asynchronous).
